spi_slave_rx_tx: RTL
====================

Name: spi_slave_rx_tx

Overview:
- Mode-0 (CPOL=0, CPHA=0), MSB-first SPI slave; the peripheral end of one chip-select line of the SPI master.
- Oversamples sclk, cs_n and mosi on the system clock.
- Delivers each received word with a one-cycle valid strobe.
- Shifts out a word supplied through a one-entry transmit buffer with a valid/ready handshake.

Parameters:
- DATA_WIDTH, 8, bits per SPI frame and width of tx_data/rx_data.
- SYNC_STAGES, 2, synchronizer flops on sclk, cs_n and mosi (minimum 2).

Ports:
- clk  in  1  system clock; f_clk >= 4*f_sclk required.
- rst_n  in  1  reset; asynchronous, active-low.
- sclk  in  1  SPI clock from master.
- cs_n  in  1  chip select from master (cs1/cs2 of the master), active-low.
- mosi  in  1  master-out data.
- miso  out  1  slave-out data.
- tx_data  in  DATA_WIDTH  next word to transmit.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  transmit buffer empty.
- rx_data  out  DATA_WIDTH  last complete received word; held until the next completion.
- rx_valid  out  1  one-cycle pulse, rx_data updated.
- frame_err  out  1  one-cycle pulse, frame aborted mid-word.
- busy  out  1  high while in SHIFT state.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Outputs: miso=0, rx_data=0, rx_valid=0, tx_ready=1, frame_err=0, busy=0.
  - Synchronizers: cs_n chain=1, sclk chain=0, mosi chain=0.
  - Internal: bit_cnt=0, shifters=0, buffer empty, state IDLE.
- Synchronization: sclk_s, cs_n_s and mosi_s are the last synchronizer stage. An edge is detected when the last stage differs from its delayed copy. Detection latency is SYNC_STAGES+1 clk from the pin edge.
- Frame-start load (used on cs_n_s fall and on word completion):
  - buffer full: tx_shift <= buffer, buffer becomes empty.
  - buffer empty: tx_shift <= 0.
- State IDLE:
  - miso=0, busy=0.
  - On cs_n_s falling edge: perform frame-start load, miso <= MSB of the loaded word, bit_cnt=0, go to SHIFT.
- State SHIFT:
  - sclk_s rising edge:
    - rx_shift <= {rx_shift[W-2:0], mosi_s}; bit_cnt++.
    - When bit_cnt was W-1: rx_data <= completed word, rx_valid=1 for the next cycle, bit_cnt=0, perform frame-start load for a back-to-back word.
  - sclk_s falling edge: tx_shift shifts left by 1, miso <= new MSB. After the last rising edge of a word, the falling edge presents the MSB of the reloaded word.
  - cs_n_s rising edge:
    - Go to IDLE, miso=0.
    - bit_cnt!=0: frame_err pulses for 1 clk; the partial word is discarded and rx_data is unchanged.
    - bit_cnt==0: no pulse.
    - A word already loaded into tx_shift is dropped and not returned to the buffer.
- Transmit handshake:
  - tx_ready = buffer empty.
  - tx_valid && tx_ready captures tx_data; tx_ready drops the next cycle.
  - tx_valid while not ready is ignored; the buffer is not overwritten.
  - Same-cycle frame-start load and capture: the load sees the buffer empty and shifts 0x00; the new word stays in the buffer.
- Simultaneous events in one clk:
  - cs_n_s rise with sclk_s rise: cs_n takes priority, the edge is ignored, and frame_err applies per bit_cnt.
  - cs_n_s fall with sclk_s rise: the sclk rise is ignored.
- Reset mid-frame: everything returns to reset values immediately; no rx_valid and no frame_err are generated.
- rx_valid depends only on word completion; it is not gated by any consumer ready.

Optional Feature:
- Macro: SPI_SLAVE_MISO_TRISTATE_EN.
- Defined: miso is high-impedance ('z) whenever state is IDLE or rst_n=0, and is driven only in SHIFT. This allows several slaves to share one miso line.
- Not defined: miso is driven 0 when not shifting (point-to-point wiring).

Test Plan:
- Reset with cs_n=1, then release -> miso=0 (or z with macro), tx_ready=1, rx_valid=0, rx_data=0x00, busy=0.
- Write tx_data=0xA5; master sends 0x3C with clk=20ns and sclk period 160ns -> miso bit sequence 1,0,1,0,0,1,0,1; rx_valid pulses once; rx_data=0x3C; tx_ready=1 again after the cs_n fall.
- Two back-to-back words with cs_n held low, sending 0x01 then 0xFE, buffer refilled with 0x77 during word 1 -> two rx_valid pulses (0x01, 0xFE); second word miso = 0x77.
- No tx write before frame -> miso outputs 0x00; rx still received correctly.
- cs_n raised after 3 sclk rises -> frame_err one pulse; rx_valid stays 0; rx_data keeps previous value; next full frame is received correctly.
- rst_n pulled low after 5 bits of a frame, released, then a full frame of 0x5A -> no rx_valid/frame_err for the aborted frame; rx_data=0x5A after the new frame.

Source files
------------

// File: rtl/spi_slave_rx_tx.sv
// Mode-0 MSB-first SPI slave with oversampled inputs, rx strobe and one-entry tx buffer.
// Optional: define SPI_SLAVE_MISO_TRISTATE_EN to release miso ('z) whenever not shifting.
module spi_slave_rx_tx #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_sclk,
    input  logic                  i_cs_n,
    input  logic                  i_mosi,
    output logic                  o_miso,
    input  logic [DATA_WIDTH-1:0] i_tx_data,
    input  logic                  i_tx_valid,
    output logic                  o_tx_ready,
    output logic [DATA_WIDTH-1:0] o_rx_data,
    output logic                  o_rx_valid,
    output logic                  o_frame_err,
    output logic                  o_busy
);
    localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);

    typedef enum logic {StIdle, StShift} state_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
    logic                   r_sclk_d, r_cs_d;
    logic                   w_sclk_s, w_cs_s, w_mosi_s;
    logic                   w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;

    state_t                 r_state;
    logic [CntW-1:0]        r_bit_cnt;
    logic [DATA_WIDTH-2:0]  r_rx_shift;
    logic [DATA_WIDTH-1:0]  r_tx_shift;
    logic [DATA_WIDTH-1:0]  r_buf;
    logic                   r_buf_full;
    logic                   r_miso;
    logic [DATA_WIDTH-1:0]  r_rx_data;
    logic                   r_rx_valid, r_frame_err, r_busy;

    logic                   w_last_bit, w_load, w_capture;
    logic [DATA_WIDTH-1:0]  w_load_word, w_rx_next;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
            r_sclk_d    <= w_sclk_s;
            r_cs_d      <= w_cs_s;
        end
    end

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
    assign w_cs_rise   = w_cs_s & ~r_cs_d;
    assign w_cs_fall   = ~w_cs_s & r_cs_d;

    assign w_last_bit  = (r_bit_cnt == CntW'(DATA_WIDTH - 1));
    assign w_rx_next   = {r_rx_shift, w_mosi_s};
    // Frame-start load: on cs fall in idle, or on word completion for a back-to-back word.
    assign w_load      = ((r_state == StIdle) && w_cs_fall) ||
                         ((r_state == StShift) && !w_cs_rise && w_sclk_rise && w_last_bit);
    assign w_load_word = r_buf_full ? r_buf : '0;
    assign w_capture   = i_tx_valid && !r_buf_full;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_bit_cnt   <= '0;
            r_rx_shift  <= '0;
            r_tx_shift  <= '0;
            r_buf       <= '0;
            r_buf_full  <= 1'b0;
            r_miso      <= 1'b0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;

            // A load in the capture cycle sees the buffer empty; the new word stays buffered.
            if (w_load && r_buf_full) begin
                r_buf_full <= 1'b0;
            end else if (w_capture) begin
                r_buf_full <= 1'b1;
                r_buf      <= i_tx_data;
            end

            case (r_state)
                StIdle: begin
                    r_miso <= 1'b0;
                    r_busy <= 1'b0;
                    if (w_cs_fall) begin
                        r_tx_shift <= w_load_word;
                        r_miso     <= w_load_word[DATA_WIDTH-1];
                        r_bit_cnt  <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= StShift;
                    end
                end
                StShift: begin
                    if (w_cs_rise) begin
                        r_state     <= StIdle;
                        r_miso      <= 1'b0;
                        r_busy      <= 1'b0;
                        r_frame_err <= (r_bit_cnt != '0);
                        r_bit_cnt   <= '0;
                    end else if (w_sclk_rise) begin
                        r_rx_shift <= w_rx_next[DATA_WIDTH-2:0];
                        if (w_last_bit) begin
                            r_rx_data  <= w_rx_next;
                            r_rx_valid <= 1'b1;
                            r_bit_cnt  <= '0;
                            r_tx_shift <= w_load_word;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + CntW'(1);
                        end
                    end else if (w_sclk_fall) begin
                        // bit_cnt==0 here means a fresh word was just loaded: present its MSB.
                        if (r_bit_cnt == '0) begin
                            r_miso <= r_tx_shift[DATA_WIDTH-1];
                        end else begin
                            r_tx_shift <= r_tx_shift << 1;
                            r_miso     <= r_tx_shift[DATA_WIDTH-2];
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    assign o_miso = (r_state == StShift) ? r_miso : 1'bz;
`else
    assign o_miso = r_miso;
`endif

    assign o_tx_ready  = ~r_buf_full;
    assign o_rx_data   = r_rx_data;
    assign o_rx_valid  = r_rx_valid;
    assign o_frame_err = r_frame_err;
    assign o_busy      = r_busy;

endmodule
